// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        ERR   = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_forward_unit.sv
// Operand forwarding selects for the D-stage comparator and the E-stage ALU.
module forward_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] write_regM,
    input  logic [4:0] write_regW,
    input  logic       reg_writeM,
    input  logic       reg_writeW,
    output logic       forward_AD,
    output logic       forward_BD,
    output logic [1:0] forward_AE,
    output logic [1:0] forward_BE
);

    // M-stage results are newer than W-stage results, so M wins.
    always_comb begin
        forward_AD = reg_writeM && reg_match(rsD, write_regM);
        forward_BD = reg_writeM && reg_match(rtD, write_regM);

        if (reg_writeM && reg_match(rsE, write_regM)) begin
            forward_AE = FWD_MEM;
        end else if (reg_writeW && reg_match(rsE, write_regW)) begin
            forward_AE = FWD_WB;
        end else begin
            forward_AE = FWD_RF;
        end

        if (reg_writeM && reg_match(rtE, write_regM)) begin
            forward_BE = FWD_MEM;
        end else if (reg_writeW && reg_match(rtE, write_regW)) begin
            forward_BE = FWD_WB;
        end else begin
            forward_BE = FWD_RF;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, stall and memory-wait controller for a 5-stage pipeline with a
// timeout trap on the data memory handshake and a stall performance counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       write_regE,
    input  logic [4:0]       write_regM,
    input  logic [4:0]       write_regW,
    input  logic             reg_writeE,
    input  logic             reg_writeM,
    input  logic             reg_writeW,
    input  logic             mem_to_regE,
    input  logic             mem_to_regM,
    input  logic             mem_writeM,
    input  logic             branchD,
    input  logic             jumpD,
    input  logic             pc_srcD,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             stallW,
    output logic             flushD,
    output logic             flushE,
    output logic             forward_AD,
    output logic             forward_BD,
    output logic [1:0]       forward_AE,
    output logic [1:0]       forward_BE,
    output logic             dmem_req,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [8:0] TIMEOUT_C = 9'(TIMEOUT);

    state_e           state_q,    state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             bus_err_q,  bus_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic lw_stall_s;
    logic br_stall_s;
    logic hazard_s;
    logic data_stall_s;

    forward_unit u_forward_unit (
        .rsD        (rsD),
        .rtD        (rtD),
        .rsE        (rsE),
        .rtE        (rtE),
        .write_regM (write_regM),
        .write_regW (write_regW),
        .reg_writeM (reg_writeM),
        .reg_writeW (reg_writeW),
        .forward_AD (forward_AD),
        .forward_BD (forward_BD),
        .forward_AE (forward_AE),
        .forward_BE (forward_BE)
    );

    // Hazard detection and stall/flush priority: ERR, then data stall, then the rest.
    always_comb begin
        lw_stall_s = mem_to_regE && (reg_match(rtE, rsD) || reg_match(rtE, rtD));
        br_stall_s = branchD &&
                     ((reg_writeE && (reg_match(write_regE, rsD) || reg_match(write_regE, rtD))) ||
                      (mem_to_regM && (reg_match(write_regM, rsD) || reg_match(write_regM, rtD))));
        hazard_s   = lw_stall_s || br_stall_s;

        dmem_req     = 1'b0;
        data_stall_s = 1'b0;
        stallF       = 1'b0;
        stallD       = 1'b0;
        stallE       = 1'b0;
        stallM       = 1'b0;
        stallW       = 1'b0;
        flushD       = 1'b0;
        flushE       = 1'b0;

        if (!rst) begin
            dmem_req = 1'b0;
        end else if (state_q == ERR) begin
            {stallF, stallD, stallE, stallM, stallW} = 5'b11111;
        end else begin
            dmem_req     = mem_to_regM || mem_writeM;
            data_stall_s = dmem_req && !dmem_ready;
            if (data_stall_s) begin
                {stallF, stallD, stallE, stallM, stallW} = 5'b11111;
            end else begin
                stallF = hazard_s || !imem_ready;
                stallD = hazard_s || !imem_ready;
                flushE = hazard_s || !imem_ready;
                // A held D register must not be cleared underneath the stall.
                flushD = (pc_srcD || jumpD) && !stallD;
            end
        end
    end

    // Memory-wait FSM, timeout trap and saturating stall counter.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        bus_err_d   = bus_err_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            RUN: begin
                if (data_stall_s) begin
                    state_d    = DWAIT;
                    wait_cnt_d = 8'd0;
                end else begin
                    state_d = RUN;
                end
            end
            DWAIT: begin
                if (!data_stall_s) begin
                    state_d = RUN;
                end else if (({1'b0, wait_cnt_q} + 9'd1) == TIMEOUT_C) begin
                    state_d   = ERR;
                    bus_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERR: begin
                state_d   = ERR;
                bus_err_d = 1'b1;
            end
            default: begin
                state_d   = ERR;
                bus_err_d = 1'b1;
            end
        endcase

        if (stallF && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            bus_err_q   <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_err_q   <= bus_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus_err   = bus_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a short timeout and a narrow stall counter.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, write_regE, write_regM, write_regW;
    logic       reg_writeE, reg_writeM, reg_writeW, mem_to_regE, mem_to_regM, mem_writeM;
    logic       branchD, jumpD, pc_srcD, imem_ready, dmem_ready;
    logic       stallF, stallD, stallE, stallM, stallW, flushD, flushE;
    logic       forward_AD, forward_BD, dmem_req, bus_err;
    logic [1:0] forward_AE, forward_BE;
    logic [3:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    pipeline_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .write_regE(write_regE), .write_regM(write_regM), .write_regW(write_regW),
        .reg_writeE(reg_writeE), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
        .mem_to_regE(mem_to_regE), .mem_to_regM(mem_to_regM), .mem_writeM(mem_writeM),
        .branchD(branchD), .jumpD(jumpD), .pc_srcD(pc_srcD),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE),
        .forward_AD(forward_AD), .forward_BD(forward_BD),
        .forward_AE(forward_AE), .forward_BE(forward_BE),
        .dmem_req(dmem_req), .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        write_regE = 5'd0; write_regM = 5'd0; write_regW = 5'd0;
        reg_writeE = 1'b0; reg_writeM = 1'b0; reg_writeW = 1'b0;
        mem_to_regE = 1'b0; mem_to_regM = 1'b0; mem_writeM = 1'b0;
        branchD = 1'b0; jumpD = 1'b0; pc_srcD = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] stalls();
        return {27'd0, stallF, stallD, stallE, stallM, stallW};
    endfunction

    function automatic logic [31:0] flushes();
        return {30'd0, flushD, flushE};
    endfunction

    initial begin
        // Reset with hazards present: outputs must stay quiet.
        clear_inputs();
        rst = 1'b0;
        mem_to_regE = 1'b1; rtE = 5'd5; rsD = 5'd5; imem_ready = 1'b0;
        mem_to_regM = 1'b1; dmem_ready = 1'b0; pc_srcD = 1'b1;
        #1;
        chk("rst_stalls", stalls(), 32'd0);
        chk("rst_flush", flushes(), 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        tick();
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        rst = 1'b1;
        clear_inputs();
        #1;
        chk("idle_stalls", stalls(), 32'd0);

        // Forwarding.
        rsE = 5'd3; write_regM = 5'd3; reg_writeM = 1'b1; write_regW = 5'd3; reg_writeW = 1'b1;
        #1; chk("fwdAE_mem_prio", {30'd0, forward_AE}, 32'd2);
        rsE = 5'd0;
        #1; chk("fwdAE_r0", {30'd0, forward_AE}, 32'd0);
        rsE = 5'd4; write_regW = 5'd4; rtE = 5'd4;
        #1; chk("fwdAE_wb", {30'd0, forward_AE}, 32'd1);
        chk("fwdBE_wb", {30'd0, forward_BE}, 32'd1);
        reg_writeW = 1'b0;
        #1; chk("fwdBE_nowrite", {30'd0, forward_BE}, 32'd0);
        rsD = 5'd3; rtD = 5'd9;
        #1; chk("fwdAD", {31'd0, forward_AD}, 32'd1);
        chk("fwdBD_nomatch", {31'd0, forward_BD}, 32'd0);
        clear_inputs();

        // Load-use hazard, with a taken branch that must not flush D.
        mem_to_regE = 1'b1; rtE = 5'd5; rsD = 5'd5; pc_srcD = 1'b1;
        #1;
        chk("lu_stalls", stalls(), 32'b11000);
        chk("lu_flush", flushes(), 32'b01);
        tick();
        clear_inputs();
        #1;
        chk("lu_cnt", {28'd0, stall_cnt}, 32'd1);
        chk("lu_released", stalls(), 32'd0);
        mem_to_regE = 1'b1;
        #1; chk("lu_r0_none", stalls(), 32'd0);
        clear_inputs();

        // Branch hazard, then resolution.
        branchD = 1'b1; reg_writeE = 1'b1; write_regE = 5'd7; rtD = 5'd7; pc_srcD = 1'b1;
        #1;
        chk("br_stalls", stalls(), 32'b11000);
        chk("br_flush", flushes(), 32'b01);
        tick();
        reg_writeE = 1'b0;
        #1;
        chk("br_resolved_flush", flushes(), 32'b10);
        chk("br_resolved_stalls", stalls(), 32'd0);
        clear_inputs();
        jumpD = 1'b1;
        #1; chk("jump_flush", flushes(), 32'b10);

        // Instruction memory not ready blocks the jump flush.
        imem_ready = 1'b0;
        #1;
        chk("imem_stalls", stalls(), 32'b11000);
        chk("imem_flush", flushes(), 32'b01);
        tick();
        clear_inputs();
        #1;
        chk("imem_cnt", {28'd0, stall_cnt}, 32'd3);

        // Data stall for three cycles, instruction memory also not ready.
        mem_to_regM = 1'b1; dmem_ready = 1'b0; imem_ready = 1'b0; jumpD = 1'b1;
        #1;
        chk("ds1_stalls", stalls(), 32'b11111);
        chk("ds1_flush", flushes(), 32'd0);
        chk("ds1_req", {31'd0, dmem_req}, 32'd1);
        tick();
        chk("ds2_stalls", stalls(), 32'b11111);
        tick();
        chk("ds3_stalls", stalls(), 32'b11111);
        tick();
        dmem_ready = 1'b1; imem_ready = 1'b1; jumpD = 1'b0;
        #1;
        chk("ds4_release", stalls(), 32'd0);
        chk("ds4_req", {31'd0, dmem_req}, 32'd1);
        tick();
        chk("ds_cnt", {28'd0, stall_cnt}, 32'd6);
        chk("ds_no_err", {31'd0, bus_err}, 32'd0);
        clear_inputs();

        // Timeout: one RUN stall cycle plus four DWAIT cycles.
        mem_writeM = 1'b1; dmem_ready = 1'b0;
        tick(); tick(); tick(); tick();
        chk("to_not_yet", {31'd0, bus_err}, 32'd0);
        chk("to_waiting", stalls(), 32'b11111);
        tick();
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_cnt", {28'd0, stall_cnt}, 32'd11);
        mem_writeM = 1'b0; mem_to_regM = 1'b1; dmem_ready = 1'b1;
        #1;
        chk("err_stalls", stalls(), 32'b11111);
        chk("err_flush", flushes(), 32'd0);
        chk("err_req", {31'd0, dmem_req}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("err_sticky", {31'd0, bus_err}, 32'd1);
        chk("cnt_saturate", {28'd0, stall_cnt}, 32'd15);

        // Reset out of ERR.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rerst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rerst_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rerst_stalls", stalls(), 32'd0);
        chk("rerst_req_run", {31'd0, dmem_req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
